// File: rtl/uart_tx_arb.sv
// Two-requester arbiter feeding one UART transmitter through per-requester one-byte slots.
// Define UART_TX_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module uart_tx_arb #(
    parameter int unsigned TMO = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] req0_data,
    input  logic       req0_we,
    output logic       req0_full,
    input  logic [7:0] req1_data,
    input  logic       req1_we,
    output logic       req1_full,
    output logic [7:0] tx_data,
    output logic       tx_we,
    input  logic       tx_busy,
    output logic       grant,
    output logic [1:0] ovf,
    input  logic       ovf_clr
);

    localparam logic [3:0] TmoLast = 4'(TMO - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitHi,
        StWaitLo
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] full_q, full_d;
    logic [7:0] slot0_q, slot0_d;
    logic [7:0] slot1_q, slot1_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       grant_q, grant_d;
    logic [1:0] ovf_q, ovf_d;
    logic [3:0] tmo_q, tmo_d;

    logic [1:0] wr;
    logic [1:0] rel;
    logic [1:0] accept;
    logic       win;

    // Winner index when at least one slot is full.
    always_comb begin
`ifdef UART_TX_ARB_RR_EN
        if (full_q == 2'b11) begin
            win = ~grant_q;
        end else begin
            win = ~full_q[0];
        end
`else
        win = ~full_q[0];
`endif
    end

    // A write landing on the slot being released in ISSUE is a clean refill, not an overrun.
    always_comb begin
        wr      = {req1_we, req0_we};
        rel     = 2'b00;
        if (state_q == StIssue) begin
            rel = grant_q ? 2'b10 : 2'b01;
        end
        accept  = wr & (~full_q | rel);
        full_d  = accept | (full_q & ~rel);
        slot0_d = accept[0] ? req0_data : slot0_q;
        slot1_d = accept[1] ? req1_data : slot1_q;
        ovf_d   = (ovf_clr ? 2'b00 : ovf_q) | (wr & ~accept);
    end

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        grant_d   = grant_q;
        tmo_d     = tmo_q;
        tx_we     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if ((|full_q) && !tx_busy) begin
                    state_d   = StIssue;
                    tx_data_d = win ? slot1_q : slot0_q;
                    grant_d   = win;
                end
            end
            StIssue: begin
                tx_we   = 1'b1;
                tmo_d   = 4'd0;
                state_d = StWaitHi;
            end
            StWaitHi: begin
                if (tx_busy) begin
                    state_d = StWaitLo;
                    tmo_d   = 4'd0;
                end else if (tmo_q == TmoLast) begin
                    // UART never acknowledged; treat the byte as sent.
                    state_d = StIdle;
                    tmo_d   = 4'd0;
                end else begin
                    tmo_d = tmo_q + 4'd1;
                end
            end
            StWaitLo: begin
                if (!tx_busy) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            full_q    <= 2'b00;
            slot0_q   <= 8'h00;
            slot1_q   <= 8'h00;
            tx_data_q <= 8'h00;
            grant_q   <= 1'b1;
            ovf_q     <= 2'b00;
            tmo_q     <= 4'd0;
        end else begin
            state_q   <= state_d;
            full_q    <= full_d;
            slot0_q   <= slot0_d;
            slot1_q   <= slot1_d;
            tx_data_q <= tx_data_d;
            grant_q   <= grant_d;
            ovf_q     <= ovf_d;
            tmo_q     <= tmo_d;
        end
    end

    assign req0_full = full_q[0];
    assign req1_full = full_q[1];
    assign tx_data   = tx_data_q;
    assign grant     = grant_q;
    assign ovf       = ovf_q;

endmodule
